// File: rtl/mem_8_arbiter_pkg.sv
// Shared types and defaults for the mem_8 arbiter slice.
package mem_8_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 8;
    localparam int STAT_W = 16;

endpackage

// File: rtl/mem_8_arbiter_stat.sv
// Saturating host-access and engine-stall counters, synchronously clearable.
module mem_8_arb_stat
    import mem_8_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              host_inc,
    input  logic              stall_inc,
    output logic [STAT_W-1:0] host_cnt,
    output logic [STAT_W-1:0] stall_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_cnt  <= '0;
            stall_cnt <= '0;
        end else if (clr) begin
            host_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (host_inc && host_cnt != '1)
                host_cnt <= host_cnt + 1'b1;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_8_arbiter.sv
// Single-port RAM shared by host (highest), clear sequencer, then local engine.
// Optional statistics counters built only when MEM_8_ARB_STAT_EN is defined.
module mem_8_arbiter
    import mem_8_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic              bus_clk,
    input  logic              rst,
    input  logic              host_wren,
    input  logic              host_rden,
    input  logic [AW-1:0]     host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic [DW-1:0]     host_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [AW-1:0]     eng_addr,
    input  logic [DW-1:0]     eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DW-1:0]     eng_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_host_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
);

    logic [DW-1:0] mem [2**AW];

    clr_state_t    state, state_next;
    logic [AW-1:0] counter, counter_next;
    logic          host_act, clr_act, clr_last;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    assign host_act = host_wren | host_rden;
    assign clr_busy = (state == CLEAR);
    assign clr_act  = clr_busy && !host_act;
    assign clr_last = clr_act && (counter == '1);
    // Grant is combinational so it marks exactly the cycle the engine owns the port.
    assign eng_gnt  = eng_req && !host_act && !clr_busy && !rst;

    always_comb begin
        ram_addr  = eng_addr;
        ram_wdata = eng_wdata;
        ram_we    = 1'b0;
        if (host_act) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            ram_we    = host_wren;
        end else if (clr_act) begin
            ram_addr  = counter;
            ram_wdata = '0;
            ram_we    = 1'b1;
        end else if (eng_gnt) begin
            ram_we    = eng_we;
        end
    end

    assign ram_rdata = mem[ram_addr];

    always_ff @(posedge bus_clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next   = CLEAR;
                    counter_next = '0;
                end
            end
            CLEAR: begin
                if (clr_act)
                    counter_next = counter + 1'b1;
                if (clr_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            clr_done   <= 1'b0;
            host_rdata <= '0;
            eng_rdata  <= '0;
            eng_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            clr_done   <= clr_last;
            eng_rvalid <= eng_gnt && !eng_we;
            if (host_rden)
                host_rdata <= ram_rdata;
            if (eng_gnt && !eng_we)
                eng_rdata <= ram_rdata;
        end
    end

`ifdef MEM_8_ARB_STAT_EN
    mem_8_arb_stat u_stat (
        .clk       (bus_clk),
        .rst       (rst),
        .clr       (stat_clr),
        .host_inc  (host_act),
        .stall_inc (eng_req && !eng_gnt),
        .host_cnt  (stat_host_cnt),
        .stall_cnt (stat_stall_cnt)
    );
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_host_cnt   = '0;
    assign stat_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_8_arbiter.sv
// Randomized, model-checked bench for mem_8_arbiter (default or MEM_8_ARB_STAT_EN build).
module tb_mem_8_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          bus_clk, rst;
    logic          host_wren, host_rden;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          eng_req, eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata, eng_rdata;
    logic          eng_gnt, eng_rvalid;
    logic          clr_start, clr_busy, clr_done;
    logic          stat_clr;
    logic [15:0]   stat_host_cnt, stat_stall_cnt;

    mem_8_arbiter #(.AW(AW), .DW(DW)) dut (
        .bus_clk(bus_clk), .rst(rst),
        .host_wren(host_wren), .host_rden(host_rden), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .stat_clr(stat_clr), .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // Reference model: memory image plus the observable registers.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_hrd, m_erd;
    bit            m_rvalid, m_busy, m_done;
    int            m_ptr, m_hcnt, m_scnt;
    int            vectors, miscompares;

    function automatic bit m_gnt();
        return eng_req && !(host_wren || host_rden) && !m_busy && !rst;
    endfunction

    function automatic int exp_hcnt();
`ifdef MEM_8_ARB_STAT_EN
        return m_hcnt;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_scnt();
`ifdef MEM_8_ARB_STAT_EN
        return m_scnt;
`else
        return 0;
`endif
    endfunction

    // Advances the model by one clock using current inputs, then the DUT.
    task automatic tick();
        bit host, g, was_busy;
        if (rst) begin
            m_hrd = '0; m_erd = '0; m_rvalid = 0; m_busy = 0; m_done = 0;
            m_ptr = 0; m_hcnt = 0; m_scnt = 0;
        end else begin
            host     = host_wren || host_rden;
            g        = m_gnt();
            was_busy = m_busy;
            m_done   = 0;
            m_rvalid = g && !eng_we;
            if (stat_clr) begin
                m_hcnt = 0; m_scnt = 0;
            end else begin
                if (host && m_hcnt < 65535) m_hcnt++;
                if (eng_req && !g && m_scnt < 65535) m_scnt++;
            end
            if (host) begin
                if (host_rden) m_hrd = m_mem[host_addr];
                if (host_wren) m_mem[host_addr] = host_wdata;
            end else if (m_busy) begin
                m_mem[m_ptr] = '0;
                if (m_ptr == DEPTH - 1) begin
                    m_busy = 0; m_done = 1; m_ptr = 0;
                end else begin
                    m_ptr++;
                end
            end else if (g) begin
                if (eng_we) m_mem[eng_addr] = eng_wdata;
                else        m_erd = m_mem[eng_addr];
            end
            if (clr_start && !was_busy) begin
                m_busy = 1; m_ptr = 0;
            end
        end
        @(posedge bus_clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_wren = 0; host_rden = 0; eng_req = 0; clr_start = 0; stat_clr = 0;
    endtask

    task automatic host_write(input int a, input int d);
        host_wren = 1; host_addr = AW'(a); host_wdata = DW'(d);
        tick();
        host_wren = 0;
    endtask

    task automatic host_read(input int a);
        host_rden = 1; host_addr = AW'(a);
        tick();
        host_rden = 0;
    endtask

    task automatic fill(input int d);
        for (int a = 0; a < DEPTH; a++) host_write(a, d);
    endtask

    task automatic test_reset();
        rst = 1; eng_req = 1; eng_we = 0; eng_addr = '0; eng_wdata = '0;
        #1;
        vectors++;
        if (eng_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt got %b want 0", eng_gnt); end
        tick(); tick();
        vectors += 7;
        if (host_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_host_rdata got %h want 00", host_rdata); end
        if (eng_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_eng_rdata got %h want 00", eng_rdata); end
        if (eng_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", eng_rvalid); end
        if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", clr_busy); end
        if (clr_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", clr_done); end
        if (stat_host_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_hcnt got %h want 0", stat_host_cnt); end
        if (stat_stall_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_scnt got %h want 0", stat_stall_cnt); end
        eng_req = 0;
        rst = 0;
        tick();
    endtask

    task automatic test_host_rw();
        for (int a = 0; a < DEPTH; a++) host_write(a, $urandom_range(0, 255));
        for (int a = DEPTH - 1; a >= 0; a--) begin
            host_read(a);
            vectors++;
            if (host_rdata !== m_hrd) begin miscompares++; $display("FAIL host_read[%0d] got %h want %h", a, host_rdata, m_hrd); end
        end
        host_write(3, 8'hA5);
        host_read(3);
        vectors++;
        if (host_rdata !== 8'hA5) begin miscompares++; $display("FAIL host_a5 got %h want a5", host_rdata); end
        tick(); tick();
        vectors++;
        if (host_rdata !== 8'hA5) begin miscompares++; $display("FAIL host_hold got %h want a5", host_rdata); end
    endtask

    task automatic test_read_first();
        logic [DW-1:0] old_v;
        old_v = m_mem[7];
        host_wren = 1; host_rden = 1; host_addr = 7; host_wdata = ~old_v;
        tick();
        idle_inputs();
        vectors++;
        if (host_rdata !== old_v) begin miscompares++; $display("FAIL read_first got %h want %h", host_rdata, old_v); end
        host_read(7);
        vectors++;
        if (host_rdata !== ~old_v) begin miscompares++; $display("FAIL read_after_write got %h want %h", host_rdata, ~old_v); end
    endtask

    task automatic test_engine_stall();
        stat_clr = 1; tick(); stat_clr = 0;
        eng_req = 1; eng_we = 0; eng_addr = 3; eng_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            host_rden = 1; host_addr = AW'(10 + k);
            #1;
            vectors++;
            if (eng_gnt !== 1'b0) begin miscompares++; $display("FAIL stall_gnt[%0d] got %b want 0", k, eng_gnt); end
            tick();
        end
        host_rden = 0;
        #1;
        vectors++;
        if (eng_gnt !== 1'b1) begin miscompares++; $display("FAIL grant_5th got %b want 1", eng_gnt); end
        tick();
        eng_req = 0;
        vectors += 3;
        if (eng_rvalid !== 1'b1) begin miscompares++; $display("FAIL eng_rvalid got %b want 1", eng_rvalid); end
        if (eng_rdata !== 8'hA5) begin miscompares++; $display("FAIL eng_rdata got %h want a5", eng_rdata); end
        if (int'(stat_stall_cnt) !== exp_hcnt() * 0 + exp_scnt()) begin
            miscompares++; $display("FAIL stall_cnt got %0d want %0d", stat_stall_cnt, exp_scnt());
        end
        tick();
        vectors += 2;
        if (eng_rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_pulse got %b want 0", eng_rvalid); end
        if (eng_rdata !== 8'hA5) begin miscompares++; $display("FAIL eng_rdata_hold got %h want a5", eng_rdata); end
    endtask

    task automatic test_engine_write();
        eng_req = 1; eng_we = 1; eng_addr = 20; eng_wdata = 8'h3C;
        #1;
        vectors++;
        if (eng_gnt !== 1'b1) begin miscompares++; $display("FAIL eng_write_gnt got %b want 1", eng_gnt); end
        tick();
        eng_req = 0;
        vectors++;
        if (eng_rvalid !== 1'b0) begin miscompares++; $display("FAIL eng_write_rvalid got %b want 0", eng_rvalid); end
        host_read(20);
        vectors++;
        if (host_rdata !== 8'h3C) begin miscompares++; $display("FAIL eng_write_data got %h want 3c", host_rdata); end
    endtask

    task automatic test_random();
        bit g;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 3);
            host_rden  = (r == 1 || r == 3);
            host_wren  = (r == 2 || r == 3);
            host_addr  = AW'($urandom_range(0, DEPTH - 1));
            host_wdata = DW'($urandom_range(0, 255));
            if (!eng_req && $urandom_range(0, 1) == 1) begin
                eng_req   = 1;
                eng_we    = ($urandom_range(0, 2) == 0);
                eng_addr  = AW'($urandom_range(0, DEPTH - 1));
                eng_wdata = DW'($urandom_range(0, 255));
            end
            clr_start = ($urandom_range(0, 99) == 0);
            stat_clr  = ($urandom_range(0, 31) == 0);
            #1;
            g = m_gnt();
            vectors++;
            if (eng_gnt !== g) begin miscompares++; $display("FAIL rnd_gnt[%0d] got %b want %b", i, eng_gnt, g); end
            tick();
            if (g) eng_req = 0;
            vectors += 7;
            if (host_rdata !== m_hrd) begin miscompares++; $display("FAIL rnd_host_rdata[%0d] got %h want %h", i, host_rdata, m_hrd); end
            if (eng_rvalid !== m_rvalid) begin miscompares++; $display("FAIL rnd_rvalid[%0d] got %b want %b", i, eng_rvalid, m_rvalid); end
            if (eng_rdata !== m_erd) begin miscompares++; $display("FAIL rnd_eng_rdata[%0d] got %h want %h", i, eng_rdata, m_erd); end
            if (clr_busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy[%0d] got %b want %b", i, clr_busy, m_busy); end
            if (clr_done !== m_done) begin miscompares++; $display("FAIL rnd_done[%0d] got %b want %b", i, clr_done, m_done); end
            if (int'(stat_host_cnt) !== exp_hcnt()) begin miscompares++; $display("FAIL rnd_hcnt[%0d] got %0d want %0d", i, stat_host_cnt, exp_hcnt()); end
            if (int'(stat_stall_cnt) !== exp_scnt()) begin miscompares++; $display("FAIL rnd_scnt[%0d] got %0d want %0d", i, stat_stall_cnt, exp_scnt()); end
        end
        idle_inputs();
        for (int k = 0; k < 80 && m_busy; k++) tick();
        tick();
    endtask

    task automatic test_clear_full();
        int busy_n, done_n;
        fill(8'hFF);
        clr_start = 1; tick(); clr_start = 0;
        busy_n = 0; done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (clr_busy === 1'b1) busy_n++;
            if (clr_done === 1'b1) done_n++;
            tick();
        end
        vectors += 2;
        if (busy_n !== 32) begin miscompares++; $display("FAIL clear_busy_cycles got %0d want 32", busy_n); end
        if (done_n !== 1) begin miscompares++; $display("FAIL clear_done_pulses got %0d want 1", done_n); end
        for (int a = 0; a < DEPTH; a++) begin
            host_read(a);
            vectors++;
            if (host_rdata !== 8'h00) begin miscompares++; $display("FAIL clear_read[%0d] got %h want 00", a, host_rdata); end
        end
    endtask

    task automatic test_clear_host();
        int k;
        fill(8'hFF);
        clr_start = 1; tick(); clr_start = 0;
        host_write(31, 8'h22);
        tick(); tick();
        host_write(0, 8'h11);
        for (k = 0; k < 60 && m_busy; k++) tick();
        tick();
        vectors++;
        if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL clear_host_finish got busy %b want 0", clr_busy); end
        host_read(0);
        vectors++;
        if (host_rdata !== 8'h11) begin miscompares++; $display("FAIL clear_host_addr0 got %h want 11", host_rdata); end
        host_read(31);
        vectors++;
        if (host_rdata !== 8'h00) begin miscompares++; $display("FAIL clear_host_addr31 got %h want 00", host_rdata); end
    endtask

    task automatic test_clear_abort();
        int done_n;
        fill(8'hFF);
        clr_start = 1; tick(); clr_start = 0;
        for (int k = 0; k < 40 && m_ptr != 10; k++) tick();
        #2;
        rst = 1;
        #1;
        vectors += 2;
        if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", clr_busy); end
        if (clr_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", clr_done); end
        tick(); tick();
        rst = 0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) done_n++;
            tick();
        end
        vectors++;
        if (done_n !== 0) begin miscompares++; $display("FAIL abort_quiet got %0d active cycles want 0", done_n); end
        for (int a = 0; a < DEPTH; a++) begin
            host_read(a);
            vectors++;
            if (host_rdata !== (a < 10 ? 8'h00 : 8'hFF)) begin
                miscompares++; $display("FAIL abort_mem[%0d] got %h want %h", a, host_rdata, (a < 10 ? 8'h00 : 8'hFF));
            end
        end
    endtask

    task automatic test_stat();
        stat_clr = 1; tick(); stat_clr = 0;
`ifdef MEM_8_ARB_STAT_EN
        host_rden = 1; host_addr = 0;
        for (int k = 0; k < 70000; k++) tick();
        vectors++;
        if (stat_host_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stat_saturate got %h want ffff", stat_host_cnt); end
        stat_clr = 1; tick(); stat_clr = 0;
        host_rden = 0;
        vectors++;
        if (stat_host_cnt !== 16'h0000) begin miscompares++; $display("FAIL stat_clr got %h want 0000", stat_host_cnt); end
`else
        host_rden = 1; eng_req = 1; eng_we = 0; eng_addr = 1;
        for (int k = 0; k < 20; k++) tick();
        idle_inputs();
        vectors += 2;
        if (stat_host_cnt !== 16'h0) begin miscompares++; $display("FAIL stat_off_host got %h want 0", stat_host_cnt); end
        if (stat_stall_cnt !== 16'h0) begin miscompares++; $display("FAIL stat_off_stall got %h want 0", stat_stall_cnt); end
`endif
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 0;
        idle_inputs();
        host_addr = '0; host_wdata = '0;
        eng_we = 0; eng_addr = '0; eng_wdata = '0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 'x;
        #2;
        test_reset();
        test_host_rw();
        test_read_first();
        test_engine_stall();
        test_engine_write();
        test_random();
        test_clear_full();
        test_clear_host();
        test_clear_abort();
        test_stat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_8_arbiter.md
MEM_8_ARBITER -- requirements
Module: mem_8_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 5, address width (depth 2^AW); DW, default 8, data width.
REQ-002 SHALL have port bus_clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port host_wren, input, 1, host write strobe (from the Xillybus mem_8 write side).
REQ-005 SHALL have port host_rden, input, 1, host read strobe.
REQ-006 SHALL have port host_addr, input, AW, host address.
REQ-007 SHALL have port host_wdata, input, DW, host write data.
REQ-008 SHALL have port host_rdata, output, DW, host read data.
REQ-009 SHALL have ports eng_req (in,1), eng_we (in,1), eng_addr (in,AW), eng_wdata (in,DW): local engine request.
REQ-010 SHALL have ports eng_gnt (out,1), eng_rvalid (out,1), eng_rdata (out,DW): engine response.
REQ-011 SHALL have ports clr_start (in,1), clr_busy (out,1), clr_done (out,1): memory-clear sequencer control.
REQ-012 SHALL have ports stat_clr (in,1), stat_host_cnt (out,16), stat_stall_cnt (out,16).

Function
REQ-013 SHALL contain one single-port 2^AW x DW RAM; exactly one access per cycle; fixed priority host > clear > engine.
REQ-014 Host access is never stalled; host_rden SHALL load host_rdata with RAM[host_addr] on the next edge (latency 1); host_rdata holds otherwise.
REQ-015 host_wren and host_rden in the same cycle SHALL both complete; read returns pre-write contents (read-first).
REQ-016 eng_gnt SHALL pulse high for exactly the cycle its access is performed: eng_req high, no host strobe, clr_busy low.
REQ-017 Engine SHALL hold eng_req/eng_we/eng_addr/eng_wdata stable until eng_gnt; arbiter SHALL sample them only at grant.
REQ-018 Engine read granted in cycle N SHALL give eng_rvalid high with eng_rdata = RAM[eng_addr] in cycle N+1; eng_rdata holds otherwise.
REQ-019 Clear FSM states IDLE, CLEAR: clr_start in IDLE -> CLEAR, counter=0, clr_busy=1 on next cycle; clr_start in CLEAR ignored.
REQ-020 In CLEAR, each cycle without host strobe SHALL write zero to RAM[counter] and increment; host cycles stall the counter.
REQ-021 After writing address 2^AW-1, FSM SHALL return to IDLE, clr_busy=0, clr_done high exactly one cycle.
REQ-022 Host write during CLEAR to an address >= counter SHALL be overwritten with zero; to address < counter SHALL persist.

Reset
REQ-023 rst SHALL asynchronously force IDLE, counter=0, host_rdata=0, eng_rdata=0, eng_gnt=0, eng_rvalid=0, clr_busy=0, clr_done=0, stat counters=0; RAM contents are not reset.
REQ-024 rst during CLEAR SHALL abort with no clr_done pulse.

Configuration
REQ-025 With MEM_8_ARB_STAT_EN defined: stat_host_cnt counts host-access cycles, stat_stall_cnt counts cycles with eng_req high and eng_gnt low; both 16-bit saturating at 0xFFFF, zeroed synchronously by stat_clr (stat_clr wins over increment).
REQ-026 Without MEM_8_ARB_STAT_EN: stat outputs SHALL be constant zero, no counter logic; ports remain.

Structure
REQ-027 Shared package mem_8_arb_pkg SHALL hold clear-FSM state enum, default AW/DW, stat width 16.
REQ-028 Counters SHALL be one sub-module mem_8_arb_stat, instantiated only under MEM_8_ARB_STAT_EN.

Verification
REQ-029 Host write 0xA5 @3, host_rden @3 next cycle -> host_rdata=0xA5 one cycle later.
REQ-030 eng_req read @3 concurrent with 4 host strobe cycles -> eng_gnt on 5th cycle, eng_rvalid next cycle, eng_rdata=0xA5, stat_stall_cnt=4.
REQ-031 RAM filled 0xFF, clr_start, no host traffic -> clr_busy 32 cycles, clr_done pulse once, all reads return 0x00.
REQ-032 During clear host writes 0x11 @0 after counter passes 0 and 0x22 @31 early -> RAM[0]=0x11, RAM[31]=0x00.
REQ-033 rst asserted mid-clear at counter 10 -> clr_busy=0 immediately, no clr_done, RAM[10..31] unchanged.
REQ-034 STAT_EN build, 70000 host cycles -> stat_host_cnt=0xFFFF; stat_clr -> 0 next cycle.
